// File: rtl/shift_frame_ctrl.sv
// ----------------------------------------------------------------------------
// shift_frame_ctrl
//
// Serial-to-parallel frame capture controller. A start request opens a frame.
// WIDTH serial bits are then sampled MSB-first from si, and the assembled word
// is presented on po with a po_valid/po_ready handshake. The word is held until
// the consumer accepts it. A start that arrives while an unaccepted word is
// held is dropped and recorded in the sticky overrun flag.
//
// Optional build feature (macro PARITY_CHECK_EN):
//   Adds a PARITY state that samples one extra even-parity bit after the data
//   bits. It also adds the par_err output, which flags a parity mismatch for
//   the frame currently on po. With the macro undefined the block has no
//   PARITY state and no par_err port.
//
// WIDTH legal range: 2..32.
// ----------------------------------------------------------------------------
module shift_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             si,
    input  logic             start,
    input  logic             abort,
    input  logic             po_ready,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             busy,
    output logic             overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic             par_err
`endif
);

    // Counter wide enough to hold the values 0..WIDTH.
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
    // The full data word must stay in the shift register while the parity
    // bit is sampled, so every bit of it is kept.
    localparam int SR_W = WIDTH;
`else
    // The final data bit goes straight from si into po. The register only
    // has to keep the bits sampled before it.
    localparam int SR_W = WIDTH - 1;
`endif

    // NOTE: explicit encodings keep the state codes the same whether or not
    // PARITY exists, which keeps debug dumps comparable between builds.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef PARITY_CHECK_EN
        ST_PARITY = 2'd2,
`endif
        ST_HOLD   = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [SR_W-1:0]   shift_q;
    logic [WIDTH-1:0]  word_d;
    logic              last_bit;
    logic [WIDTH-1:0]  po_q;
    logic              po_valid_q;
    logic              busy_q;
    logic              overrun_q;
`ifdef PARITY_CHECK_EN
    logic              par_err_q;
`endif

    // Next-state values of the datapath for a SHIFT cycle: the new bit enters
    // at bit 0, so the first sampled bit ends up at the word's MSB.
`ifdef PARITY_CHECK_EN
    assign word_d = {shift_q[WIDTH-2:0], si};
`else
    assign word_d = {shift_q, si};
`endif
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign last_bit = (cnt_q == LAST_BIT);

    // Frame control FSM together with its registered outputs. The async clear
    // forces every register to its idle value at once, so a partial frame is
    // dropped and no stale handshake survives the reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            // NOTE: every state register here uses non-blocking assignment,
            // so all branches see the values from before this clock edge.
            unique case (state_q)
                ST_IDLE: begin
                    // si is deliberately not sampled in the start cycle.
                    if (start) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    // abort beats start. start is simply ignored while a
                    // frame is in progress and never counts as an overrun.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        shift_q <= word_d[SR_W-1:0];
                        cnt_q   <= cnt_d;
                        if (last_bit) begin
`ifdef PARITY_CHECK_EN
                            state_q <= ST_PARITY;
`else
                            state_q    <= ST_HOLD;
                            po_q       <= word_d;
                            po_valid_q <= 1'b1;
                            busy_q     <= 1'b0;
`endif
                        end
                    end
                end

`ifdef PARITY_CHECK_EN
                ST_PARITY: begin
                    // Even parity: data bits XOR parity bit must be 0.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= ST_HOLD;
                        cnt_q      <= '0;
                        po_q       <= shift_q;
                        par_err_q  <= (^shift_q) ^ si;
                        po_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
`endif

                ST_HOLD: begin
                    // po stays frozen until the consumer accepts it. When
                    // start comes with acceptance, the next frame begins
                    // without passing through IDLE.
                    if (po_ready) begin
                        po_valid_q <= 1'b0;
                        if (start) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (start) begin
                        overrun_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign po       = po_q;
    assign po_valid = po_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
`ifdef PARITY_CHECK_EN
    assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_frame_ctrl
//
// Directed bench for shift_frame_ctrl with WIDTH=4. It runs in the default
// build, and also with PARITY_CHECK_EN defined. Each frame pushes its expected
// word (and parity flag) to a scoreboard queue when the frame's stimulus is
// driven. The entry is popped and compared when po_valid appears.
// ----------------------------------------------------------------------------
module tb_shift_frame_ctrl;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    logic             clk;
    logic             clr_n;
    logic             si;
    logic             start;
    logic             abort;
    logic             po_ready;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             busy;
    logic             overrun;
`ifdef PARITY_CHECK_EN
    logic             par_err;
`endif

    exp_t scoreboard[$];
    int   errors = 0;
    int   checks = 0;

    shift_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .si       (si),
        .start    (start),
        .abort    (abort),
        .po_ready (po_ready),
        .po       (po),
        .po_valid (po_valid),
        .busy     (busy),
        .overrun  (overrun)
`ifdef PARITY_CHECK_EN
        ,
        .par_err  (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one complete frame: the start cycle, then WIDTH data bits MSB-first,
    // then the parity bit in parity builds. hold_start keeps start high during
    // the shifting cycles, where it must be ignored.
    task automatic run_frame(input logic [WIDTH-1:0] data, input logic pbit,
                             input logic hold_start, input string tag);
        exp_t e;
        e.word = data;
        e.perr = (^data) ^ pbit;
        scoreboard.push_back(e);
        start = 1'b1;
        tick();
        start    = 1'b0;
        po_ready = 1'b0;
        check({tag, "_busy_first"}, busy, 1'b1);
        check({tag, "_valid_first"}, po_valid, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            si    = data[i];
            start = hold_start;
            tick();
        end
`ifdef PARITY_CHECK_EN
        check({tag, "_busy_parity"}, busy, 1'b1);
        si = pbit;
        tick();
`endif
        start = 1'b0;
        si    = 1'b0;
        collect(tag);
    endtask

    // Pop the oldest expected frame and compare it with what the DUT presents.
    task automatic collect(input string tag);
        exp_t e;
        check({tag, "_valid_latency"}, po_valid, 1'b1);
        check({tag, "_busy_hold"}, busy, 1'b0);
        check({tag, "_sb_nonempty"}, scoreboard.size() > 0, 1'b1);
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            check({tag, "_po"}, po, e.word);
`ifdef PARITY_CHECK_EN
            check({tag, "_par_err"}, par_err, e.perr);
`endif
        end
    endtask

    // Consumer accepts the held word in a single cycle, without a new start.
    task automatic accept(input logic [WIDTH-1:0] last_word, input string tag);
        po_ready = 1'b1;
        tick();
        po_ready = 1'b0;
        check({tag, "_valid_drop"}, po_valid, 1'b0);
        check({tag, "_po_retained"}, po, last_word);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] rnd;

        clr_n    = 1'b0;
        si       = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        po_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_po", po, '0);
        check("rst_valid", po_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        clr_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 1'b0);

        // First frame 1,0,1,1 with exact latency. Parity bit 0 gives an error.
        run_frame(4'b1011, 1'b0, 1'b0, "f1");

        // Backpressure: the word stays stable for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_po", po, 4'b1011);
            check("bp_valid", po_valid, 1'b1);
        end
        accept(4'b1011, "f1_acc");

        // start held during SHIFT is ignored and does not set overrun.
        run_frame(4'b0101, 1'b0, 1'b1, "f2");
        check("f2_no_overrun", overrun, 1'b0);

        // Lost start in HOLD sets overrun; the FSM keeps holding the word.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovr_set", overrun, 1'b1);
        check("ovr_valid", po_valid, 1'b1);
        check("ovr_busy", busy, 1'b0);
        check("ovr_po", po, 4'b0101);

        // abort in HOLD has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_hold_valid", po_valid, 1'b1);
        check("abort_hold_po", po, 4'b0101);

        // Accept and start in the same HOLD cycle: back-to-back frame.
        po_ready = 1'b1;
        run_frame(4'b0110, 1'b1, 1'b0, "f3");
        check("f3_overrun_sticky", overrun, 1'b1);
        accept(4'b0110, "f3_acc");

        // abort after two data bits, with start also high (abort wins).
        start = 1'b1;
        tick();
        start = 1'b0;
        si = 1'b1;
        tick();
        si = 1'b0;
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", po_valid, 1'b0);
        check("abort_po", po, 4'b0110);
        tick();
        check("abort_idle_busy", busy, 1'b0);

        // abort in IDLE has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_valid", po_valid, 1'b0);

        run_frame(4'b1100, 1'b0, 1'b0, "f4");
        accept(4'b1100, "f4_acc");

`ifdef PARITY_CHECK_EN
        // Matching even-parity bit gives no error.
        run_frame(4'b1011, 1'b1, 1'b0, "fp");
        accept(4'b1011, "fp_acc");
`endif

        // Asynchronous reset in the middle of a frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        si = 1'b1;
        tick();
        tick();
        #3;
        clr_n = 1'b0;
        #1;
        check("arst_po", po, '0);
        check("arst_valid", po_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_overrun", overrun, 1'b0);
        si = 1'b0;
        tick();
        clr_n = 1'b1;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            check("arst_no_valid", po_valid, 1'b0);
        end
        check("arst_still_idle", busy, 1'b0);

        // Random frame after the reset.
        rnd = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        run_frame(rnd, rnd[0], 1'b0, "frnd");
        accept(rnd, "frnd_acc");

        check("sb_empty", scoreboard.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
